// File: rtl/product_accumulator_pkg.sv
// Shared constants and clamp-limit helpers for the product accumulator slice.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
//
// Contents: default product/accumulator widths and the signed min/max values
// that an ACC_W-bit accumulator saturates to.
package product_accumulator_pkg;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 12;

  // Largest positive value representable in acc_w signed bits.
  function automatic longint sat_max(input int acc_w);
    return (longint'(1) << (acc_w - 1)) - 1;
  endfunction

  // Most negative value representable in acc_w signed bits.
  function automatic longint sat_min(input int acc_w);
    return -(longint'(1) << (acc_w - 1));
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / frame-sum-out handshake bundle for the product accumulator.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the product side and the sum side.
//
// Signals:
//   in_valid / in_ready / in_product : product stream from the multiplier
//   out_valid / out_ready            : frame result handshake
//   out_sum / out_ovf                : signed frame sum and overflow flag
// Modports: slave = accumulator side, master = producer/consumer side.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_product;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     out_ovf;

  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/product_accumulator_acc_sat_add.sv
// Adds a sign-extended product to the running accumulator, clamping or wrapping on overflow.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   acc  in  ACC_W   current signed accumulator
//   prod in  PROD_W  signed product
//   sum  out ACC_W   clamped (SATURATE=1) or wrapped (SATURATE=0) sum
//   ovf  out 1       true sum did not fit in ACC_W bits
module product_accumulator_acc_sat_add
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W   = PROD_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int SATURATE = 1
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam int EXT_W = ACC_W + 1 - PROD_W;
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SUM_MIN = ACC_W'(sat_min(ACC_W));

  // One guard bit is always enough to hold the exact sum of an ACC_W-bit and
  // an ACC_W-or-narrower operand, so wide[ACC_W] is the true sign.
  logic [ACC_W:0] wide;

  assign wide = {acc[ACC_W-1], acc} + {{EXT_W{prod[PROD_W-1]}}, prod};

  // Guard bit disagreeing with the ACC_W-bit sign bit means it did not fit.
  assign ovf = wide[ACC_W] ^ wide[ACC_W-1];

  always_comb begin
    sum = wide[ACC_W-1:0];
    if (ovf && (SATURATE != 0)) begin
      sum = wide[ACC_W] ? SUM_MIN : SUM_MAX;
    end
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums FRAME_LEN consecutive products into one signed frame result with overflow flag.
// Latency: result is valid the cycle after the frame's last product is accepted.
// Backpressure: a held result stalls only the product that would complete the next frame.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clear  in   synchronous flush of the in-progress frame (held result untouched)
//   bus    slave modport of product_accumulator_if (product in, frame sum out)
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int FRAME_LEN = 4,
  parameter int SATURATE  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  product_accumulator_if.slave   bus
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic                    ovf_sticky;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_sum_q;
  logic                    out_ovf_q;

  logic                    last_term;
  logic                    in_ready;
  logic                    accept;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;

  product_accumulator_acc_sat_add #(
    .PROD_W   (PROD_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .acc  (acc),
    .prod (bus.in_product),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  assign last_term = (count == LAST_CNT);

  // Only the frame-completing term has to wait for the output register to
  // drain; earlier terms land in acc and never touch the held result.
  assign in_ready = !clear && !(out_valid_q && !bus.out_ready && last_term);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      count       <= '0;
      ovf_sticky  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      // Frame state
      if (clear || (accept && last_term)) begin
        acc        <= '0;
        count      <= '0;
        ovf_sticky <= 1'b0;
      end else if (accept) begin
        acc        <= add_sum;
        count      <= count + CNT_W'(1);
        ovf_sticky <= ovf_sticky | add_ovf;
      end

      // Output register: a completing frame reloads it even while the old
      // result is being consumed, so back-to-back frames have no bubble.
      if (accept && last_term) begin
        out_valid_q <= 1'b1;
        out_sum_q   <= add_sum;
        out_ovf_q   <= ovf_sticky | add_ovf;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: four instances (wide/saturating, narrow/saturating,
// narrow/wrapping, odd frame length) share one input stream; a frame-level model
// predicts ready, valid and results, and directed frames pin literal expectations.
module tb_product_accumulator;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic out_ready;
  logic signed [7:0] in_product;

  int total;
  int bad;

  // Per-instance configuration mirrored into the model.
  int accw [N] = '{12, 8, 8, 9};
  bit satm [N] = '{1'b1, 1'b1, 1'b0, 1'b0};
  int flen [N] = '{4, 4, 4, 3};

  product_accumulator_if #(.PROD_W(8), .ACC_W(12)) if0 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(8))  if1 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(8))  if2 ();
  product_accumulator_if #(.PROD_W(8), .ACC_W(9))  if3 ();

  product_accumulator #(.PROD_W(8), .ACC_W(12), .FRAME_LEN(4), .SATURATE(1))
    dut0 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0));
  product_accumulator #(.PROD_W(8), .ACC_W(8), .FRAME_LEN(4), .SATURATE(1))
    dut1 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1));
  product_accumulator #(.PROD_W(8), .ACC_W(8), .FRAME_LEN(4), .SATURATE(0))
    dut2 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if2));
  product_accumulator #(.PROD_W(8), .ACC_W(9), .FRAME_LEN(3), .SATURATE(0))
    dut3 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if3));

  assign if0.in_valid = in_valid;  assign if0.in_product = in_product;  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.in_product = in_product;  assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.in_product = in_product;  assign if2.out_ready = out_ready;
  assign if3.in_valid = in_valid;  assign if3.in_product = in_product;  assign if3.out_ready = out_ready;

  logic o_rdy [N];
  logic o_vld [N];
  logic o_ovf [N];
  int   o_sum [N];

  assign o_rdy[0] = if0.in_ready;  assign o_vld[0] = if0.out_valid;  assign o_ovf[0] = if0.out_ovf;  assign o_sum[0] = int'(if0.out_sum);
  assign o_rdy[1] = if1.in_ready;  assign o_vld[1] = if1.out_valid;  assign o_ovf[1] = if1.out_ovf;  assign o_sum[1] = int'(if1.out_sum);
  assign o_rdy[2] = if2.in_ready;  assign o_vld[2] = if2.out_valid;  assign o_ovf[2] = if2.out_ovf;  assign o_sum[2] = int'(if2.out_sum);
  assign o_rdy[3] = if3.in_ready;  assign o_vld[3] = if3.out_valid;  assign o_ovf[3] = if3.out_ovf;  assign o_sum[3] = int'(if3.out_sum);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int frbuf [N][0:255];   // products of the frame in progress
  int fcnt  [N];
  bit ev    [N];          // a result is expected on the output
  int es    [N];
  bit eo    [N];

  // Exact frame sum with range checking after every term; clamps or wraps
  // according to the instance's mode.
  function automatic void fold(input int k, output int s, output bit o);
    int a;
    int t;
    int lo;
    int hi;
    int m;
    a  = 0;
    o  = 1'b0;
    hi = (1 << (accw[k] - 1)) - 1;
    lo = -(1 << (accw[k] - 1));
    for (int i = 0; i < flen[k]; i++) begin
      t = a + frbuf[k][i];
      if (t > hi || t < lo) begin
        o = 1'b1;
        if (satm[k]) begin
          a = (t > hi) ? hi : lo;
        end else begin
          m = t & ((1 << accw[k]) - 1);
          a = (m > hi) ? m - (1 << accw[k]) : m;
        end
      end else begin
        a = t;
      end
    end
    s = a;
  endfunction

  function automatic bit model_ready(input int k);
    return !clear && !(ev[k] && !out_ready && (fcnt[k] == flen[k] - 1));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit r;
    bit done;
    int s;
    bit o;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        fcnt[k] = 0;
        ev[k]   = 1'b0;
        es[k]   = 0;
        eo[k]   = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        r    = model_ready(k);
        done = 1'b0;
        if (clear) begin
          fcnt[k] = 0;
        end else if (in_valid && r) begin
          frbuf[k][fcnt[k]] = int'(in_product);
          fcnt[k] = fcnt[k] + 1;
          if (fcnt[k] == flen[k]) begin
            fold(k, s, o);
            es[k]   = s;
            eo[k]   = o;
            fcnt[k] = 0;
            done    = 1'b1;
          end
        end
        if (done)
          ev[k] = 1'b1;
        else if (out_ready)
          ev[k] = 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("dut%0d.in_ready", k), int'(o_rdy[k]), int'(model_ready(k)));
        chk($sformatf("dut%0d.out_valid", k), int'(o_vld[k]), int'(ev[k]));
        if (ev[k]) begin
          chk($sformatf("dut%0d.out_sum", k), o_sum[k], es[k]);
          chk($sformatf("dut%0d.out_ovf", k), int'(o_ovf[k]), int'(eo[k]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change just after a rising edge and are settled well before the next one.
  task automatic drive(input bit v, input int p, input bit ordy, input bit clr);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_product = 8'(p);
    out_ready  = ordy;
    clear      = clr;
    #1;
  endtask

  task automatic frame4(input int a, input int b, input int c, input int d, input bit ordy);
    drive(1'b1, a, ordy, 1'b0);
    drive(1'b1, b, ordy, 1'b0);
    drive(1'b1, c, ordy, 1'b0);
    drive(1'b1, d, ordy, 1'b0);
  endtask

  initial begin
    int p;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    clear      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_product = '0;

    // Reset state
    #3;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset dut%0d.out_valid", k), int'(o_vld[k]), 0);
      chk($sformatf("reset dut%0d.out_sum", k), o_sum[k], 0);
      chk($sformatf("reset dut%0d.out_ovf", k), int'(o_ovf[k]), 0);
    end
    #9 rst_n = 1'b1;

    // Basic sum: 6 - 8 + 64 - 56 = 6
    frame4(6, -8, 64, -56, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("basic out_valid", int'(o_vld[0]), 1);
    chk("basic out_sum", o_sum[0], 6);
    chk("basic out_ovf", int'(o_ovf[0]), 0);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("basic out_valid drop", int'(o_vld[0]), 0);

    // Saturation on 8-bit accumulator: 127, 119, 111 with overflow seen
    frame4(64, 64, -8, -8, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("sat out_sum", o_sum[1], 111);
    chk("sat out_ovf", int'(o_ovf[1]), 1);
    chk("wide no-sat out_sum", o_sum[0], 112);

    // Wrap mode: 64 + 64 wraps to -128
    frame4(64, 64, 0, 0, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("wrap out_sum", o_sum[2], -128);
    chk("wrap out_ovf", int'(o_ovf[2]), 1);
    chk("clamp out_sum", o_sum[1], 127);
    chk("wide out_sum", o_sum[0], 128);
    chk("wide out_ovf", int'(o_ovf[0]), 0);

    // Back-pressure: frame A held, frame B stalls only on its last term
    frame4(1, 2, 3, 4, 1'b0);
    drive(1'b1, 5, 1'b0, 1'b0);
    chk("bp A out_sum", o_sum[0], 10);
    drive(1'b1, 5, 1'b0, 1'b0);
    drive(1'b1, 5, 1'b0, 1'b0);
    drive(1'b1, 5, 1'b0, 1'b0);
    chk("bp stall in_ready", int'(o_rdy[0]), 0);
    drive(1'b1, 5, 1'b0, 1'b0);
    chk("bp hold out_sum", o_sum[0], 10);
    chk("bp hold out_valid", int'(o_vld[0]), 1);
    drive(1'b1, 5, 1'b1, 1'b0);
    chk("bp release in_ready", int'(o_rdy[0]), 1);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("bp B out_valid", int'(o_vld[0]), 1);
    chk("bp B out_sum", o_sum[0], 20);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("bp B drained", int'(o_vld[0]), 0);

    // Clear beats a concurrent valid
    drive(1'b1, 7, 1'b1, 1'b0);
    drive(1'b1, 7, 1'b1, 1'b0);
    drive(1'b1, 9, 1'b1, 1'b1);
    chk("clear in_ready", int'(o_rdy[0]), 0);
    frame4(1, 1, 1, 1, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("after clear out_sum", o_sum[0], 4);
    chk("after clear out_valid", int'(o_vld[0]), 1);

    // Async reset mid-frame with a result pending
    frame4(3, 3, 3, 3, 1'b0);
    drive(1'b1, 10, 1'b0, 1'b0);
    drive(1'b1, 10, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("pre-reset out_sum", o_sum[0], 12);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", int'(o_vld[0]), 0);
    chk("mid reset out_sum", o_sum[0], 0);
    chk("mid reset out_ovf", int'(o_ovf[0]), 0);
    #2 rst_n = 1'b1;
    frame4(2, 2, 2, 2, 1'b1);
    drive(1'b0, 0, 1'b1, 1'b0);
    chk("post reset out_sum", o_sum[0], 8);
    chk("post reset out_ovf", int'(o_ovf[0]), 0);
    chk("post reset out_valid", int'(o_vld[0]), 1);

    // Randomised traffic with extremes, stalls, clears and one reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        p = ($urandom_range(0, 1) == 0) ? 127 : -128;
      else
        p = int'($signed(8'($urandom)));
      drive($urandom_range(0, 9) < 7, p, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    drive(1'b0, 0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
Downstream consumer of the 4x4 signed Booth multiplier's 8-bit product. It accepts products over a valid/ready handshake and sums FRAME_LEN consecutive products into a wider signed accumulator, with optional saturation. It emits one frame sum per frame through an output register with back-pressure. Accumulation of the next frame continues while an unconsumed result waits.

Parameters:
PROD_W, 8, signed product width; must match the multiplier output.
ACC_W, 12, signed accumulator and result width; must be >= PROD_W.
FRAME_LEN, 4, products per frame; legal range 2..255.
SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous assert, active-low
clear  in  1  synchronous flush of the in-progress frame
in_valid  in  1  in_product is valid
in_ready  out  1  block can accept in_product this cycle
in_product  in  PROD_W  signed product from the multiplier
out_valid  out  1  out_sum / out_ovf are valid
out_ready  in  1  consumer accepts the result
out_sum  out  ACC_W  signed frame sum
out_ovf  out  1  overflow or saturation occurred during the frame

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: acc=0, count=0, ovf_sticky=0, out_valid=0, out_sum=0, out_ovf=0.
- Accept event: in_valid && in_ready at a rising edge.
- Sign extension: in_product is sign-extended to ACC_W+1 bits before the add.
- Overflow detection: overflow is true when the ACC_W+1-bit sum does not fit in ACC_W bits.
- SATURATE=1: on overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1) by the sign of the true sum.
- SATURATE=0: on overflow, keep the low ACC_W bits.
- ovf_sticky is set on any overflowing add within the frame.
- Non-final accept (count < FRAME_LEN-1): acc <= new sum; count <= count+1.
- Final accept (count == FRAME_LEN-1): out_sum <= new sum; out_ovf <= ovf_sticky | this add's overflow; out_valid <= 1.
- Same edge as a final accept: acc, count and ovf_sticky return to 0.
- Latency: result appears the cycle after the final accept.
- Output handshake: out_valid && out_ready clears out_valid on the next edge, unless a new final accept occurs on the same edge. In that case out_valid stays 1 and the output registers load the new result; no bubble.
- in_ready = !clear && !(out_valid && !out_ready && count == FRAME_LEN-1).
- Consequence: a new frame accumulates freely while a result is held. Only the term that would complete the next frame is stalled.
- out_sum and out_ovf hold stable while out_valid && !out_ready.
- clear: on the next edge, acc, count and ovf_sticky go to 0. in_ready is 0 while clear is high, so clear beats a concurrent in_valid (no accept). clear does not affect out_valid, out_sum or out_ovf.
- Reset mid-frame: partial sum discarded and any pending result dropped (out_valid=0).
- count width: clog2(FRAME_LEN).
- No X propagation: when in_valid=0, in_product is ignored.

Decomposition:
- Shared package: PROD_W default, ACC_W default, functions sat_max(ACC_W) and sat_min(ACC_W).
- One natural sub-module: acc_sat_add. It is combinational: acc + sign-extended product, returns clamped or wrapped sum plus overflow flag, parameterised by PROD_W, ACC_W, SATURATE.
- Top level owns the count, sticky flag, output register and ready logic.

Test Plan:
- Basic sum: defaults, out_ready=1, products 6,-8,64,-56 back-to-back -> one cycle after the 4th accept out_valid=1, out_sum=6, out_ovf=0; out_valid=0 the next cycle.
- Saturation: ACC_W=8, SATURATE=1, products 64,64,-8,-8 -> 64+64 clamps to 127 (ovf), then 119, 111; out_sum=111, out_ovf=1.
- Wrap mode: ACC_W=8, SATURATE=0, products 64,64,0,0 -> out_sum=-128 (0x80), out_ovf=1.
- Back-pressure: hold out_ready=0 after frame A=(1,2,3,4) completes.
  - Send frame B=(5,5,5,5): three terms accepted, 4th sees in_ready=0, out_sum stays 10.
  - Raise out_ready -> 4th B term accepted the same cycle; next cycle out_sum=20, out_valid continuous.
- Clear vs valid: after accepting 7,7, assert clear with in_valid=1, in_product=9 -> in_ready=0, 9 not accepted. Then frame 1,1,1,1 -> out_sum=4.
- Async reset mid-frame: accept 10,10, drop rst_n between edges -> all outputs 0 immediately. After release, frame 2,2,2,2 -> out_sum=8, out_ovf=0.
